bin_morph_filter: RTL and testbench

//  Binary erosion/dilation stage fed directly by the 3x3 window generator. Consumes the

---
 rtl/bin_morph_filter_pkg.sv | 30 +++
 rtl/bin_morph_filter_kernel.sv | 78 +++++++
 rtl/bin_morph_filter.sv | 134 +++++++++++++
 tb/tb_bin_morph_filter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_morph_filter_pkg.sv
// Shared types and constants for the binary morphology filter.
package bin_morph_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_ERODE  = 2'b01,
    MODE_DILATE = 2'b10
  } mode_e;

  // Clocks from window input to filtered output.
  localparam int unsigned PIPE_LAT = 2;

  // Tap index = (row-1)*3 + (col-1); p11 is bit 0, p33 is bit 8.
  localparam logic [8:0] ROW1_MASK = 9'b000_000_111;
  localparam logic [8:0] ROW3_MASK = 9'b111_000_000;
  localparam logic [8:0] COL1_MASK = 9'b001_001_001;
  localparam logic [8:0] COL3_MASK = 9'b100_100_100;

  // Reserved encoding 11 behaves as bypass.
  function automatic mode_e decode_mode(input logic [1:0] sel);
    mode_e m;
    case (sel)
      2'b01:   m = MODE_ERODE;
      2'b10:   m = MODE_DILATE;
      default: m = MODE_BYPASS;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bin_morph_filter_kernel.sv
// Two-stage 3x3 binary kernel: edge masking then AND/OR/centre reduction.
module bin_morph_kernel
  import bin_morph_pkg::*;
#(
  parameter bit EDGE_NEUTRAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  mode_e      mode_i,
  input  logic       top_i,
  input  logic       bottom_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic [8:0] taps_i,
  output logic       valid_o,
  output logic       pix_o
);

  logic [8:0] pad_mask;
  logic       pad;
  logic [8:0] masked_d;
  logic [8:0] taps_s1_q;
  logic       valid_s1_q;
  mode_e      mode_s1_q;
  logic       red_d;
  logic       pix_q;
  logic       valid_q;

  // Stage 1: replace out-of-frame taps with the pad value; corners combine.
  always_comb begin
    pad_mask = '0;
    if (top_i)    pad_mask = pad_mask | ROW1_MASK;
    if (bottom_i) pad_mask = pad_mask | ROW3_MASK;
    if (left_i)   pad_mask = pad_mask | COL1_MASK;
    if (right_i)  pad_mask = pad_mask | COL3_MASK;
    pad      = EDGE_NEUTRAL && (mode_i == MODE_ERODE);
    masked_d = (taps_i & ~pad_mask) | (pad ? pad_mask : '0);
  end

  // Stage 1 register: masked taps travel with their valid and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      taps_s1_q  <= '0;
      valid_s1_q <= 1'b0;
      mode_s1_q  <= MODE_BYPASS;
    end else begin
      taps_s1_q  <= masked_d;
      valid_s1_q <= valid_i;
      mode_s1_q  <= mode_i;
    end
  end

  // Stage 2: reduce the 3x3 neighbourhood according to the window's mode.
  always_comb begin
    red_d = taps_s1_q[4];
    case (mode_s1_q)
      MODE_ERODE:  red_d = &taps_s1_q;
      MODE_DILATE: red_d = |taps_s1_q;
      default:     red_d = taps_s1_q[4];
    endcase
  end

  // Stage 2 register: pixel forced low whenever the window is not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pix_q   <= valid_s1_q & red_d;
      valid_q <= valid_s1_q;
    end
  end

  assign pix_o   = pix_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/bin_morph_filter.sv
// Binary erosion/dilation stage with per-frame mode latch and foreground count.
module bin_morph_filter
  import bin_morph_pkg::*;
#(
  parameter int unsigned CNT_W        = 20,
  parameter bit          EDGE_NEUTRAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_sel,
  input  logic             in_vsync,
  input  logic             in_hsync,
  input  logic             in_valid,
  input  logic             in_top_edge,
  input  logic             in_bottom_edge,
  input  logic             in_left_edge,
  input  logic             in_right_edge,
  input  logic             in_p11,
  input  logic             in_p12,
  input  logic             in_p13,
  input  logic             in_p21,
  input  logic             in_p22,
  input  logic             in_p23,
  input  logic             in_p31,
  input  logic             in_p32,
  input  logic             in_p33,
  output logic             out_vsync,
  output logic             out_hsync,
  output logic             out_valid,
  output logic             out_data,
  output logic [1:0]       frame_mode,
  output logic [CNT_W-1:0] fg_count,
  output logic             fg_count_valid
);

  logic [PIPE_LAT-1:0] vs_pipe_q;
  logic [PIPE_LAT-1:0] hs_pipe_q;
  logic                frame_start;
  mode_e               mode_q;
  mode_e               mode_d;
  logic [8:0]          taps;
  logic                k_valid;
  logic                k_pix;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [CNT_W-1:0]    fg_q;
  logic [CNT_W-1:0]    fg_d;
  logic                fgv_q;
  logic                fgv_d;
  logic                seen_q;
  logic                seen_d;

  // The first sync stage doubles as the registered vsync for edge detection.
  assign frame_start = in_vsync & ~vs_pipe_q[0];

  // A window arriving on the frame-start clock already sees the new mode.
  assign mode_d = frame_start ? decode_mode(mode_sel) : mode_q;

  assign taps = {in_p33, in_p32, in_p31,
                 in_p23, in_p22, in_p21,
                 in_p13, in_p12, in_p11};

  // Sync delay lines matched to the kernel latency; mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_pipe_q <= '0;
      hs_pipe_q <= '0;
      mode_q    <= MODE_BYPASS;
    end else begin
      vs_pipe_q <= {vs_pipe_q[PIPE_LAT-2:0], in_vsync};
      hs_pipe_q <= {hs_pipe_q[PIPE_LAT-2:0], in_hsync};
      mode_q    <= mode_d;
    end
  end

  bin_morph_kernel #(
    .EDGE_NEUTRAL(EDGE_NEUTRAL)
  ) u_kernel (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (in_valid),
    .mode_i   (mode_d),
    .top_i    (in_top_edge),
    .bottom_i (in_bottom_edge),
    .left_i   (in_left_edge),
    .right_i  (in_right_edge),
    .taps_i   (taps),
    .valid_o  (k_valid),
    .pix_o    (k_pix)
  );

  // Saturating foreground count; publish the pre-increment total on frame start.
  always_comb begin
    cnt_d  = cnt_q;
    fg_d   = fg_q;
    fgv_d  = 1'b0;
    seen_d = seen_q;
    if (k_valid && k_pix && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (frame_start) begin
      cnt_d  = '0;
      seen_d = 1'b1;
      if (seen_q) begin
        fg_d  = cnt_q;
        fgv_d = 1'b1;
      end
    end
  end

  // Counter and published-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      fg_q   <= '0;
      fgv_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fg_q   <= fg_d;
      fgv_q  <= fgv_d;
      seen_q <= seen_d;
    end
  end

  assign out_vsync      = vs_pipe_q[PIPE_LAT-1];
  assign out_hsync      = hs_pipe_q[PIPE_LAT-1];
  assign out_valid      = k_valid;
  assign out_data       = k_pix;
  assign frame_mode     = mode_q;
  assign fg_count       = fg_q;
  assign fg_count_valid = fgv_q;

endmodule

// File: tb/tb_bin_morph_filter.sv
// Scoreboard bench for bin_morph_filter: three instances (default, zero padding,
// 4-bit counter) share one stimulus stream built from an 8x6 image.
module tb_bin_morph_filter;

  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] mode_sel;
  logic       in_vsync, in_hsync, in_valid;
  logic       in_top_edge, in_bottom_edge, in_left_edge, in_right_edge;
  logic       in_p11, in_p12, in_p13, in_p21, in_p22, in_p23, in_p31, in_p32, in_p33;

  logic        o0_vs, o0_hs, o0_v, o0_d, fgv0;
  logic [1:0]  fm0;
  logic [19:0] fg0;
  logic        o1_vs, o1_hs, o1_v, o1_d, fgv1;
  logic [1:0]  fm1;
  logic [19:0] fg1;
  logic        o2_vs, o2_hs, o2_v, o2_d, fgv2;
  logic [1:0]  fm2;
  logic [3:0]  fg2;

  bin_morph_filter #(.CNT_W(20), .EDGE_NEUTRAL(1'b1)) dut0 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_valid(in_valid),
    .in_top_edge(in_top_edge), .in_bottom_edge(in_bottom_edge),
    .in_left_edge(in_left_edge), .in_right_edge(in_right_edge),
    .in_p11(in_p11), .in_p12(in_p12), .in_p13(in_p13),
    .in_p21(in_p21), .in_p22(in_p22), .in_p23(in_p23),
    .in_p31(in_p31), .in_p32(in_p32), .in_p33(in_p33),
    .out_vsync(o0_vs), .out_hsync(o0_hs), .out_valid(o0_v), .out_data(o0_d),
    .frame_mode(fm0), .fg_count(fg0), .fg_count_valid(fgv0)
  );

  bin_morph_filter #(.CNT_W(20), .EDGE_NEUTRAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_valid(in_valid),
    .in_top_edge(in_top_edge), .in_bottom_edge(in_bottom_edge),
    .in_left_edge(in_left_edge), .in_right_edge(in_right_edge),
    .in_p11(in_p11), .in_p12(in_p12), .in_p13(in_p13),
    .in_p21(in_p21), .in_p22(in_p22), .in_p23(in_p23),
    .in_p31(in_p31), .in_p32(in_p32), .in_p33(in_p33),
    .out_vsync(o1_vs), .out_hsync(o1_hs), .out_valid(o1_v), .out_data(o1_d),
    .frame_mode(fm1), .fg_count(fg1), .fg_count_valid(fgv1)
  );

  bin_morph_filter #(.CNT_W(4), .EDGE_NEUTRAL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_valid(in_valid),
    .in_top_edge(in_top_edge), .in_bottom_edge(in_bottom_edge),
    .in_left_edge(in_left_edge), .in_right_edge(in_right_edge),
    .in_p11(in_p11), .in_p12(in_p12), .in_p13(in_p13),
    .in_p21(in_p21), .in_p22(in_p22), .in_p23(in_p23),
    .in_p31(in_p31), .in_p32(in_p32), .in_p33(in_p33),
    .out_vsync(o2_vs), .out_hsync(o2_hs), .out_valid(o2_v), .out_data(o2_d),
    .frame_mode(fm2), .fg_count(fg2), .fg_count_valid(fgv2)
  );

  typedef struct packed {
    logic vs;
    logic hs;
    logic v;
    logic d_n;  // expected pixel with neutral padding
    logic d_z;  // expected pixel with zero padding
  } exp_t;

  exp_t sb_q[$];
  logic img [H][W];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state at frame level.
  int   m_mode    = 0;
  logic m_prev_vs = 1'b0;
  bit   m_seen    = 1'b0;
  int   acc0 = 0, acc1 = 0, acc2 = 0;
  int   fg_m0 = 0, fg_m1 = 0, fg_m2 = 0;
  logic fgv_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Filtered pixel from the image itself, padding outside the frame.
  function automatic logic model_pix(input int r, input int c, input int mode, input bit neutral);
    logic all1 = 1'b1;
    logic any1 = 1'b0;
    logic t;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
          t = img[r + dr][c + dc];
        else
          t = neutral && (mode == 1);
        all1 = all1 & t;
        any1 = any1 | t;
      end
    end
    if (mode == 1) return all1;
    if (mode == 2) return any1;
    return img[r][c];
  endfunction

  // One clock: compare what is due, then drive new inputs and update the model.
  task automatic cycle(input bit r, input bit vs, input bit hs, input bit v,
                       input int row, input int col);
    exp_t       e;
    logic [8:0] tp;
    int         rr, cc;
    @(negedge clk);
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      check("stream", {28'd0, o0_vs, o0_hs, o0_v, o0_d}, {28'd0, e.vs, e.hs, e.v, e.d_n});
      check("data_zero_pad", {31'd0, o1_d}, {31'd0, e.d_z});
      check("data_cnt4", {31'd0, o2_d}, {31'd0, e.d_n});
    end
    check("frame_mode", {30'd0, fm0}, m_mode);
    check("fg_count_valid", {29'd0, fgv0, fgv1, fgv2}, {29'd0, {3{fgv_m}}});
    check("fg_count", {12'd0, fg0}, fg_m0);
    check("fg_count_zero_pad", {12'd0, fg1}, fg_m1);
    check("fg_count_sat", {28'd0, fg2}, fg_m2);

    for (int i = 0; i < 9; i++) begin
      rr = row + i / 3 - 1;
      cc = col + i % 3 - 1;
      if (v && rr >= 0 && rr < H && cc >= 0 && cc < W) tp[i] = img[rr][cc];
      else tp[i] = 1'($urandom_range(0, 1));
    end
    rst      = r;
    in_vsync = vs;
    in_hsync = hs;
    in_valid = v;
    {in_p33, in_p32, in_p31, in_p23, in_p22, in_p21, in_p13, in_p12, in_p11} = tp;
    if (v) begin
      in_top_edge    = (row == 0);
      in_bottom_edge = (row == H - 1);
      in_left_edge   = (col == 0);
      in_right_edge  = (col == W - 1);
    end else begin
      {in_top_edge, in_bottom_edge, in_left_edge, in_right_edge} = 4'($urandom_range(0, 15));
    end

    fgv_m = 1'b0;
    if (r) begin
      sb_q.delete();
      sb_q.push_back('0);
      sb_q.push_back('0);
      m_mode = 0; m_prev_vs = 1'b0; m_seen = 1'b0;
      acc0 = 0; acc1 = 0; acc2 = 0;
      fg_m0 = 0; fg_m1 = 0; fg_m2 = 0;
    end else begin
      if (vs && !m_prev_vs) begin
        m_mode = (mode_sel == 2'b01) ? 1 : (mode_sel == 2'b10) ? 2 : 0;
        if (m_seen) begin
          fg_m0 = acc0; fg_m1 = acc1; fg_m2 = acc2;
          fgv_m = 1'b1;
        end
        m_seen = 1'b1;
        acc0 = 0; acc1 = 0; acc2 = 0;
      end
      m_prev_vs = vs;
      e.vs  = vs;
      e.hs  = hs;
      e.v   = v;
      e.d_n = v ? model_pix(row, col, m_mode, 1'b1) : 1'b0;
      e.d_z = v ? model_pix(row, col, m_mode, 1'b0) : 1'b0;
      if (e.d_n) begin
        acc0++;
        if (acc2 < 15) acc2++;
      end
      if (e.d_z) acc1++;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Full frame; optional mid-frame mode_sel change and mid-line reset.
  task automatic send_frame(input logic [1:0] msel, input int toggle_line,
                            input logic [1:0] msel2, input int rst_line);
    mode_sel = msel;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(2);
    for (int r = 0; r < H; r++) begin
      if (r == toggle_line) mode_sel = msel2;
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      for (int c = 0; c < W; c++) begin
        if (r == rst_line && c == 4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, r, c);
      end
      idle(2);
    end
    idle(3);
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 1'b1;
          1:       img[r][c] = (r == 3 && c == 3);
          default: img[r][c] = 1'($urandom_range(0, 1));
        endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mode_sel = 2'b00;
    in_vsync = 1'b0; in_hsync = 1'b0; in_valid = 1'b0;
    {in_top_edge, in_bottom_edge, in_left_edge, in_right_edge} = '0;
    {in_p33, in_p32, in_p31, in_p23, in_p22, in_p21, in_p13, in_p12, in_p11} = '0;
    repeat (2) @(posedge clk);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(3);

    fill(0); send_frame(2'b01, -1, 2'b00, -1);   // erode all ones; first vsync publishes nothing
    fill(1); send_frame(2'b10, -1, 2'b00, -1);   // dilate single pixel; publishes previous frame
    check("erode_all_ones", {12'd0, fg0}, 32'd48);
    check("erode_zero_pad", {12'd0, fg1}, 32'd24);
    check("erode_saturated", {28'd0, fg2}, 32'd15);
    fill(0); send_frame(2'b01, 2, 2'b10, -1);    // mode_sel changes mid-frame
    check("dilate_block", {12'd0, fg0}, 32'd9);
    fill(2); send_frame(2'b11, -1, 2'b00, -1);   // reserved mode behaves as bypass
    check("mode_held_frame", {12'd0, fg0}, 32'd48);
    fill(0); send_frame(2'b01, -1, 2'b00, 3);    // reset in the middle of line 3
    fill(0); send_frame(2'b00, -1, 2'b00, -1);   // first vsync after reset: no publish
    fill(2); send_frame(2'b10, -1, 2'b00, -1);   // second vsync publishes the bypass frame
    check("bypass_all_ones", {12'd0, fg0}, 32'd48);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
